// File: rtl/sort_frame_collector.sv
// sort_frame_collector
//   Collects a serial valid/ready sample stream into frames of
//   N = 2**LOG_INPUT_NUM samples and presents each frame as one parallel
//   vector for the bitonic sorter. Every slot's label is its arrival index.
//   A frame that ends early on s_last is filled out with PAD_VALUE.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous, active-low reset
//   s_data     incoming sample
//   s_valid    s_data valid
//   s_last     final sample of a frame (qualified by s_valid)
//   s_ready    collector can accept a sample (FILL state only)
//   x          packed frame, slot i at [i*DATA_WIDTH +: DATA_WIDTH]
//   x_label    packed labels, slot i carries i
//   x_valid    one-cycle pulse when a frame completes
//   frame_len  real samples in the frame (1..N), held with x
module sort_frame_collector #(
  parameter int unsigned           LOG_INPUT_NUM = 4,
  parameter int unsigned           DATA_WIDTH    = 8,
  parameter int unsigned           LABEL_WIDTH   = 4,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE     = 8'h7F
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [DATA_WIDTH-1:0]                       s_data,
  input  logic                                        s_valid,
  input  logic                                        s_last,
  output logic                                        s_ready,
  output logic [(2**LOG_INPUT_NUM)*DATA_WIDTH-1:0]    x,
  output logic [(2**LOG_INPUT_NUM)*LABEL_WIDTH-1:0]   x_label,
  output logic                                        x_valid,
  output logic [LOG_INPUT_NUM:0]                      frame_len
);

  localparam int unsigned N = 2**LOG_INPUT_NUM;
  localparam logic [LOG_INPUT_NUM:0] FULL_LEN = (LOG_INPUT_NUM+1)'(N);

  typedef enum logic {FILL, PAD} state_t;

  state_t                       state, state_nxt;
  logic [LOG_INPUT_NUM-1:0]     cnt, cnt_nxt;
  logic [N*DATA_WIDTH-1:0]      fill_buf, buf_nxt;
  logic [LOG_INPUT_NUM:0]       pend_len, pend_len_nxt;
  logic                         done;
  logic [N*LABEL_WIDTH-1:0]     label_const;

  // Constant slot-index labels, loaded into x_label on each frame completion.
  always_comb begin
    label_const = '0;
    for (int unsigned i = 0; i < N; i++)
      label_const[i*LABEL_WIDTH +: LABEL_WIDTH] = LABEL_WIDTH'(i);
  end

  // buf_nxt already contains the slot written this edge, so on completion it
  // is the full frame and is copied straight to the output registers.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    buf_nxt      = fill_buf;
    pend_len_nxt = pend_len;
    done         = 1'b0;
    s_ready      = 1'b0;
    case (state)
      FILL: begin
        // Held low while reset is asserted.
        s_ready = rst;
        if (s_valid) begin
          buf_nxt[cnt*DATA_WIDTH +: DATA_WIDTH] = s_data;
          if (cnt == '1) begin
            done         = 1'b1;
            pend_len_nxt = FULL_LEN;
            cnt_nxt      = '0;
          end else if (s_last) begin
            pend_len_nxt = {1'b0, cnt} + (LOG_INPUT_NUM+1)'(1);
            cnt_nxt      = cnt + LOG_INPUT_NUM'(1);
            state_nxt    = PAD;
          end else begin
            cnt_nxt = cnt + LOG_INPUT_NUM'(1);
          end
        end
      end
      PAD: begin
        buf_nxt[cnt*DATA_WIDTH +: DATA_WIDTH] = PAD_VALUE;
        if (cnt == '1) begin
          done      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = FILL;
        end else begin
          cnt_nxt = cnt + LOG_INPUT_NUM'(1);
        end
      end
      default: begin
        state_nxt = FILL;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FILL;
      cnt       <= '0;
      fill_buf  <= '0;
      pend_len  <= '0;
      x         <= '0;
      x_label   <= '0;
      x_valid   <= 1'b0;
      frame_len <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      fill_buf <= buf_nxt;
      pend_len <= pend_len_nxt;
      x_valid  <= done;
      if (done) begin
        x         <= buf_nxt;
        x_label   <= label_const;
        frame_len <= pend_len_nxt;
      end
    end
  end

endmodule
